psum_accumulator: RTL and testbench

Output stage directly downstream of the SIMD `mac`. It qualifies the MAC's unvalidated adder-tree output by delaying the operand-side `input_valid` by the MAC pipeline latency. It accumulates a configurable number of consecutive MAC results (input-channel passes) into one partial sum, then applies scale, optional ReLU and saturation. Finished results are buffered in a small FIFO behind a valid/ready interface, because the MAC itself cannot stall.

---
 rtl/psum_pkg.sv | 23 ++
 rtl/result_fifo.sv | 59 +++++
 rtl/psum_accumulator.sv | 125 ++++++++++++
 tb/tb_psum_accumulator.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum output stage and its result FIFO.
package psum_pkg;

  localparam int unsigned WIDE_WIDTH = 64;

  // Accumulator sign-extended wide enough that shift, ReLU and clamp cannot overflow.
  typedef logic signed [WIDE_WIDTH-1:0] acc_wide_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic acc_wide_t sat_trunc(input acc_wide_t value, input int unsigned width);
    acc_wide_t max_v;
    acc_wide_t min_v;
    max_v = (acc_wide_t'(1) <<< (width - 1)) - acc_wide_t'(1);
    min_v = ~max_v;
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with registered storage; a push into a full FIFO succeeds when it pops in the same cycle.
module result_fifo
  import psum_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_WIDTH = ptr_width(DEPTH);

  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               do_push;
  logic               do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                 (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);

  assign head_data = empty ? '0 : mem_q[rd_ptr_q[PTR_WIDTH-1:0]];

  always_comb begin
    do_pop   = pop && !empty && !clear;
    do_push  = push && (!full || do_pop) && !clear;
    wr_ptr_d = wr_ptr_q + (PTR_WIDTH+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (PTR_WIDTH+1)'(do_pop);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // When full, the write slot is the head slot being popped this cycle.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= push_data;
  end

endmodule

// File: rtl/psum_accumulator.sv
// Qualifies MAC output via a valid delay line, accumulates N passes, then scales,
// applies optional ReLU, saturates and buffers results behind valid/ready.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int unsigned IN_WIDTH     = 16,
  parameter int unsigned ACC_WIDTH    = 32,
  parameter int unsigned OUTPUT_WIDTH = 16,
  parameter int unsigned OUTPUT_SCALE = 0,
  parameter int unsigned MAC_LATENCY  = 6,
  parameter int unsigned PASS_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           arst_n_in,
  input  logic                           mac_valid,
  input  logic signed [IN_WIDTH-1:0]     mac_out,
  input  logic        [PASS_WIDTH-1:0]   cfg_passes,
  input  logic                           cfg_relu,
  input  logic                           clear,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUTPUT_WIDTH-1:0] out_data,
  output logic                           busy,
  output logic                           overflow
);

  logic        [MAC_LATENCY-1:0]  dl_q, dl_d;
  logic        [PASS_WIDTH-1:0]   cnt_q, cnt_d;
  logic        [PASS_WIDTH-1:0]   n_q, n_d;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                           ovf_q, ovf_d;

  logic                           q_valid;
  logic                           first_pass;
  logic                           last_pass;
  logic        [PASS_WIDTH-1:0]   n_eff;
  logic signed [ACC_WIDTH-1:0]    in_ext;
  logic signed [ACC_WIDTH-1:0]    acc_sum;
  acc_wide_t                      scaled;
  acc_wide_t                      rectified;
  logic        [OUTPUT_WIDTH-1:0] result;
  logic                           push;
  logic                           pop;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic        [OUTPUT_WIDTH-1:0] head_data;

  assign q_valid    = dl_q[MAC_LATENCY-1];
  assign first_pass = (cnt_q == '0);
  assign n_eff      = (cfg_passes == '0) ? PASS_WIDTH'(1) : cfg_passes;
  assign in_ext     = ACC_WIDTH'(mac_out);

  always_comb begin
    dl_d = clear ? '0 : ((dl_q << 1) | MAC_LATENCY'(mac_valid));

    acc_sum   = first_pass ? in_ext : (acc_q + in_ext);
    last_pass = q_valid && (first_pass ? (n_eff == PASS_WIDTH'(1))
                                       : (cnt_q == n_q - PASS_WIDTH'(1)));

    cnt_d = cnt_q;
    n_d   = n_q;
    acc_d = acc_q;
    if (q_valid) begin
      acc_d = acc_sum;
      if (first_pass) n_d = n_eff;
      cnt_d = last_pass ? '0 : (cnt_q + PASS_WIDTH'(1));
    end
    if (clear) begin
      cnt_d = '0;
      n_d   = '0;
      acc_d = '0;
    end
  end

  // Arithmetic shift on the widened sum rounds toward minus infinity.
  always_comb begin
    scaled    = acc_wide_t'(acc_sum) >>> OUTPUT_SCALE;
    rectified = (cfg_relu && scaled[WIDE_WIDTH-1]) ? '0 : scaled;
    result    = OUTPUT_WIDTH'(sat_trunc(rectified, OUTPUT_WIDTH));
  end

  always_comb begin
    push  = last_pass && !clear;
    pop   = out_valid && out_ready;
    ovf_d = clear ? 1'b0 : (ovf_q || (push && fifo_full && !pop));
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      dl_q  <= '0;
      cnt_q <= '0;
      n_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      dl_q  <= dl_d;
      cnt_q <= cnt_d;
      n_q   <= n_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  result_fifo #(
    .WIDTH (OUTPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst_n     (arst_n_in),
    .clear     (clear),
    .push      (push),
    .push_data (result),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head_data;
  assign busy      = (|dl_q) || (cnt_q != '0);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: two builds (scale 0 and scale 2) share one input stream
// and are compared every cycle against a queue-based behavioural model.
module tb_psum_accumulator;

  localparam int L = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        mac_valid = 1'b0;
  logic [15:0] mac_out = '0;
  logic [7:0]  cfg_passes = '0;
  logic        cfg_relu = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;

  logic        out_valid, busy, overflow, out_valid2, busy2, overflow2;
  logic [15:0] out_data, out_data2;

  always #5 clk = ~clk;

  psum_accumulator #(
    .IN_WIDTH(16), .ACC_WIDTH(32), .OUTPUT_WIDTH(16), .OUTPUT_SCALE(0),
    .MAC_LATENCY(L), .PASS_WIDTH(8), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .arst_n_in(arst_n), .mac_valid(mac_valid), .mac_out(mac_out),
    .cfg_passes(cfg_passes), .cfg_relu(cfg_relu), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .overflow(overflow)
  );

  psum_accumulator #(
    .IN_WIDTH(16), .ACC_WIDTH(32), .OUTPUT_WIDTH(16), .OUTPUT_SCALE(2),
    .MAC_LATENCY(L), .PASS_WIDTH(8), .FIFO_DEPTH(D)
  ) dut_s2 (
    .clk(clk), .arst_n_in(arst_n), .mac_valid(mac_valid), .mac_out(mac_out),
    .cfg_passes(cfg_passes), .cfg_relu(cfg_relu), .clear(clear),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .busy(busy2), .overflow(overflow2)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  typedef struct { int d0; int d1; } res_t;
  bit   vhist[$];
  int   ohist[$];
  int   m_cnt, m_n, m_sum;
  bit   m_ovf;
  res_t m_fifo[$];
  int   got0[$], got1[$];

  function automatic int post(input int sum, input int scale, input bit relu);
    longint s, d;
    s = sum;
    d = longint'(1) << scale;
    if (s >= 0) s = s / d;
    else        s = -((-s + d - 1) / d);
    if (relu && s < 0) s = 0;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  function automatic void reset_model();
    vhist = {};
    for (int i = 0; i < L; i++) vhist.push_back(1'b0);
    m_cnt = 0; m_n = 1; m_sum = 0; m_ovf = 1'b0;
    m_fifo = {};
  endfunction

  always @(posedge clk or negedge arst_n) begin : model
    bit   qv, pop;
    int   v;
    res_t r;
    if (!arst_n || clear) begin
      reset_model();
    end else begin
      qv = vhist.pop_front();
      vhist.push_back(mac_valid);
      pop = (m_fifo.size() > 0) && out_ready;
      if (pop) void'(m_fifo.pop_front());
      if (qv) begin
        v = int'($signed(mac_out));
        if (m_cnt == 0) begin
          m_n   = (cfg_passes == 0) ? 1 : int'(cfg_passes);
          m_sum = v;
        end else begin
          m_sum = m_sum + v;
        end
        m_cnt++;
        if (m_cnt == m_n) begin
          m_cnt = 0;
          r.d0 = post(m_sum, 0, cfg_relu);
          r.d1 = post(m_sum, 2, cfg_relu);
          if (m_fifo.size() < D) m_fifo.push_back(r);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (arst_n && !clear && out_valid && out_ready) begin
      got0.push_back(int'($signed(out_data)));
      got1.push_back(int'($signed(out_data2)));
    end
  end

  wire [37:0] obs = {out_valid, out_data, out_data2, busy, overflow, out_valid2, busy2, overflow2};

  function automatic logic [37:0] expv();
    logic ev, eb;
    logic [15:0] a, b;
    ev = (m_fifo.size() > 0);
    a  = ev ? 16'(m_fifo[0].d0) : 16'h0;
    b  = ev ? 16'(m_fifo[0].d1) : 16'h0;
    eb = (m_cnt != 0);
    foreach (vhist[i]) if (vhist[i]) eb = 1'b1;
    return {ev, a, b, eb, m_ovf, ev, eb, m_ovf};
  endfunction

  // Operand-side driver: mac_out carries the value issued L cycles earlier, as the MAC would.
  task automatic cyc(input bit v, input int val);
    mac_valid = v;
    mac_out   = 16'(ohist.pop_front());
    ohist.push_back(v ? val : int'($urandom_range(0, 65535)));
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1000 + i);
      checks++;
      if (obs !== 38'h0) begin
        failures++;
        $display("FAIL reset_outputs cyc%0d got=%h want=0", i, obs);
      end
    end
    arst_n = 1'b1;
  endtask

  task automatic test_accum();
    int vals[3] = '{100, -30, 50};
    got0 = {}; got1 = {};
    cfg_passes = 8'd3; cfg_relu = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(i < 3, vals[i % 3]);
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL accum_model cyc%0d got=%h want=%h", i, obs, expv());
      end
      checks++;
      if (out_valid !== (i == 2 + L)) begin
        failures++;
        $display("FAIL accum_valid_timing cyc%0d got=%b want=%b", i, out_valid, (i == 2 + L));
      end
    end
    checks++;
    if (got0.size() != 1 || got0[0] != 120 || busy !== 1'b0) begin
      failures++;
      $display("FAIL accum_result n=%0d first=%0d busy=%b want n=1 first=120 busy=0",
               got0.size(), (got0.size() > 0) ? got0[0] : 0, busy);
    end
  endtask

  task automatic test_sat_relu();
    int ins[8] = '{30000, 30000, -30000, -30000, -5, 2, -5, 2};
    int e0[4]  = '{32767, -32768, 0, -3};
    int e1[4]  = '{15000, -15000, 0, -1};
    got0 = {}; got1 = {};
    cfg_passes = 8'd2; out_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      cfg_relu = (p == 2);
      for (int i = 0; i < 2 + L + 2; i++) begin
        cyc(i < 2, ins[2 * p + (i % 2)]);
        checks++;
        if (obs !== expv()) begin
          failures++;
          $display("FAIL satrelu_model pair%0d cyc%0d got=%h want=%h", p, i, obs, expv());
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got0.size() != 4 || got1.size() != 4 || got0[k] != e0[k] || got1[k] != e1[k]) begin
        failures++;
        $display("FAIL satrelu_result idx%0d got=%0d/%0d want=%0d/%0d", k,
                 (got0.size() > k) ? got0[k] : 99999, (got1.size() > k) ? got1[k] : 99999, e0[k], e1[k]);
      end
    end
    cfg_relu = 1'b0;
  endtask

  task automatic test_scale();
    got0 = {}; got1 = {};
    cfg_passes = 8'd1; out_ready = 1'b1;
    for (int i = 0; i < 2 + L + 2; i++) begin
      cyc(i < 2, (i == 0) ? 7 : -7);
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL scale_model cyc%0d got=%h want=%h", i, obs, expv());
      end
    end
    checks++;
    if (got1.size() != 2 || got1[0] != 1 || got1[1] != -2 || got0[0] != 7 || got0[1] != -7) begin
      failures++;
      $display("FAIL scale_result n=%0d got=%0d,%0d want=1,-2", got1.size(),
               (got1.size() > 0) ? got1[0] : 99999, (got1.size() > 1) ? got1[1] : 99999);
    end
  endtask

  task automatic test_backpressure();
    got0 = {}; got1 = {};
    cfg_passes = 8'd1; out_ready = 1'b0;
    for (int i = 0; i < 5 + L; i++) begin
      cyc(i < 5, i + 1);
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL bp_fill_model cyc%0d got=%h want=%h", i, obs, expv());
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL bp_overflow got=%b want=1", overflow);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 0);
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL bp_drain_model cyc%0d got=%h want=%h", i, obs, expv());
      end
    end
    checks++;
    if (got0.size() != 4 || got0[0] != 1 || got0[1] != 2 || got0[2] != 3 || got0[3] != 4) begin
      failures++;
      $display("FAIL bp_order n=%0d want 1,2,3,4", got0.size());
    end
    clear = 1'b1;
    cyc(1'b0, 0);
    clear = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL bp_clear_overflow got=%b want=0", overflow);
    end
  endtask

  task automatic test_full_pop();
    got0 = {}; got1 = {};
    cfg_passes = 8'd1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 11 + i);
    for (int i = 0; i < L - 1; i++) cyc(1'b0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 0);
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL fullpop_model cyc%0d got=%h want=%h", i, obs, expv());
      end
    end
    checks++;
    if (overflow !== 1'b0 || got0.size() != 5 || got0[0] != 11 || got0[4] != 15) begin
      failures++;
      $display("FAIL fullpop_result ovf=%b n=%0d want ovf=0 n=5 11..15", overflow, got0.size());
    end
  endtask

  task automatic test_clear_mid();
    got0 = {}; got1 = {};
    cfg_passes = 8'd4; out_ready = 1'b1;
    for (int i = 0; i < 2 + L; i++) cyc(i < 2, 10);
    clear = 1'b1;
    cyc(1'b1, 10);
    clear = 1'b0;
    checks++;
    if (busy !== 1'b0 || obs !== expv()) begin
      failures++;
      $display("FAIL clear_state got=%h want=%h", obs, expv());
    end
    for (int i = 0; i < 4 + L + 2; i++) begin
      cyc(i < 4, 10);
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL clear_model cyc%0d got=%h want=%h", i, obs, expv());
      end
    end
    checks++;
    if (got0.size() != 1 || got0[0] != 40) begin
      failures++;
      $display("FAIL clear_result n=%0d first=%0d want n=1 first=40", got0.size(),
               (got0.size() > 0) ? got0[0] : 0);
    end
  endtask

  task automatic test_reset_mid();
    got0 = {}; got1 = {};
    cfg_passes = 8'd4; out_ready = 1'b1;
    for (int i = 0; i < 2 + L; i++) cyc(i < 2, 10);
    arst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 10);
      checks++;
      if (obs !== 38'h0) begin
        failures++;
        $display("FAIL rstmid_outputs cyc%0d got=%h want=0", i, obs);
      end
    end
    arst_n = 1'b1;
    for (int i = 0; i < 4 + L + 2; i++) begin
      cyc(i < 4, 10);
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL rstmid_model cyc%0d got=%h want=%h", i, obs, expv());
      end
    end
    checks++;
    if (got0.size() != 1 || got0[0] != 40) begin
      failures++;
      $display("FAIL rstmid_result n=%0d first=%0d want n=1 first=40", got0.size(),
               (got0.size() > 0) ? got0[0] : 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cfg_passes = 8'($urandom_range(0, 3));
      cfg_relu   = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 9) < 7);
      clear      = ($urandom_range(0, 99) == 0);
      cyc($urandom_range(0, 9) < 6, int'($urandom_range(0, 65535)) - 32768);
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL random_model cyc%0d got=%h want=%h", i, obs, expv());
      end
    end
    clear = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 0);
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL random_drain cyc%0d got=%h want=%h", i, obs, expv());
      end
    end
  endtask

  initial begin
    reset_model();
    for (int i = 0; i < L; i++) ohist.push_back(0);
    test_reset();
    test_accum();
    test_sat_relu();
    test_scale();
    test_backpressure();
    test_full_pop();
    test_clear_mid();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
